nn_argmax: RTL
==============

NN_ARGMAX -- requirements
Module: nn_argmax

Interface
REQ-001 SHALL have parameter NumOutputs, default 4, number of output-layer activations scanned.
REQ-002 SHALL have parameter DataWidth, default 8, activation width, signed two's complement.
REQ-003 SHALL have parameter AddrWidth, default 6, activation RAM address width; must satisfy 2**AddrWidth >= NumOutputs.
REQ-004 SHALL have parameter ClassWidth, default $clog2(NumOutputs), class index width.
REQ-005 SHALL have parameter RejectThresh, default 0, signed threshold; used only under NN_ARGMAX_REJECT_EN.
REQ-006 clk_i  input  1  sole clock, rising edge.
REQ-007 reset_i  input  1  synchronous, active-high reset.
REQ-008 req_i  input  1  upstream layer signals output activations complete.
REQ-009 ack_o  output  1  one-cycle pulse accepting req_i.
REQ-010 ready_o  output  1  high when idle and able to accept req_i.
REQ-011 actv_ram_addr_o  output  AddrWidth  read address into the output-activation RAM.
REQ-012 actv_ram_rdata_i  input  DataWidth  RAM read data, one-cycle synchronous latency.
REQ-013 class_o  output  ClassWidth  index of the maximum activation.
REQ-014 max_o  output  DataWidth  value of the maximum activation.
REQ-015 reject_o  output  1  max below threshold (constant 0 without the macro).
REQ-016 valid_o  output  1  result valid.
REQ-017 ready_i  input  1  result consumer ready; transfer when valid_o && ready_i.

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-019 IDLE: ready_o=1; req_i=1 at cycle t -> cycle t+1: ack_o=1 for exactly one cycle, state READ, actv_ram_addr_o=0.
REQ-020 READ: actv_ram_addr_o increments 0..NumOutputs-1, one per cycle; after issuing NumOutputs-1 -> DRAIN.
REQ-021 Data for address k SHALL be captured at the cycle after address k is presented; element 0 initialises running max/index unconditionally.
REQ-022 Comparison SHALL be signed; element k replaces the running max only if strictly greater (ties keep lowest index).
REQ-023 DRAIN: captures final element, registers class_o/max_o/reject_o -> DONE; valid_o rises at cycle t+NumOutputs+2.
REQ-024 DONE: valid_o=1 and class_o/max_o/reject_o held stable until valid_o && ready_i; that cycle -> IDLE, valid_o=0 next cycle.
REQ-025 req_i in any state other than IDLE SHALL be ignored (no ack_o); upstream holds req_i until ack_o.
REQ-026 ready_o SHALL be 0 in READ, DRAIN, DONE.
REQ-027 NumOutputs=1 SHALL be legal: READ issues address 0 only, class_o=0.
REQ-028 actv_ram_addr_o SHALL be held at 0 when not in READ.

Reset
REQ-029 reset_i=1 SHALL, at the next edge, force IDLE, ack_o=0, valid_o=0, class_o=0, max_o=0, reject_o=0, actv_ram_addr_o=0, from any state, aborting any scan without output.
REQ-030 ready_o SHALL be 1 the first cycle after reset deasserts.

Configuration
REQ-031 Macro NN_ARGMAX_REJECT_EN defined: reject_o = (max < RejectThresh, signed), registered with class_o.
REQ-032 Macro undefined: reject_o tied 0, no threshold comparator synthesised; all other timing identical.

Structure
REQ-033 Shared package nn_pkg SHALL hold the argmax_state_e enum (IDLE, READ, DRAIN, DONE) and constant ActvRamRdLatency=1.
REQ-034 A single sub-module nn_max_cmp (signed strict-greater compare plus index select, combinational) is natural; all state stays in nn_argmax.

Verification
REQ-035 NumOutputs=4, RAM {5,-3,12,7}, req_i at t -> ack_o at t+1, valid_o at t+6, class_o=2, max_o=12.
REQ-036 RAM {-8,-2,-2,-100} -> class_o=1, max_o=-2 (tie keeps lowest, signed compare).
REQ-037 ready_i held 0 for 5 cycles after valid_o -> outputs stable, ready_o=0, second req_i not acked until after transfer.
REQ-038 reset_i asserted for one cycle during READ at address 2 -> IDLE next cycle, valid_o never asserts, fresh req_i completes normally.
REQ-039 NN_ARGMAX_REJECT_EN, RejectThresh=10, RAM {1,4,9,3} -> class_o=2, reject_o=1; RAM {1,40,9,3} -> reject_o=0.
REQ-040 Back-to-back: req_i held high, ready_i=1 -> second ack_o one cycle after first result transfer returns to IDLE.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the nn output-layer blocks
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } argmax_state_e;

  localparam int ActvRamRdLatency = 1;

endpackage

// File: rtl/nn_max_cmp.sv
// rtl/nn_max_cmp.sv - signed strict-greater compare with index select
module nn_max_cmp #(
  parameter int DataWidth  = 8,
  parameter int ClassWidth = 2
) (
  input  logic [DataWidth-1:0]  cur_max_i,
  input  logic [ClassWidth-1:0] cur_idx_i,
  input  logic [DataWidth-1:0]  cand_i,
  input  logic [ClassWidth-1:0] cand_idx_i,
  input  logic                  init_i,
  output logic [DataWidth-1:0]  max_o,
  output logic [ClassWidth-1:0] idx_o
);

  logic take;

  // strict greater keeps the lowest index on ties; init_i seeds element 0
  assign take  = init_i || ($signed(cand_i) > $signed(cur_max_i));
  assign max_o = take ? cand_i : cur_max_i;
  assign idx_o = take ? cand_idx_i : cur_idx_i;

endmodule

// File: rtl/nn_argmax.sv
// rtl/nn_argmax.sv - argmax scan over the output-activation RAM
// NN_ARGMAX_REJECT_EN adds a registered below-threshold reject flag.
module nn_argmax
  import nn_pkg::*;
#(
  parameter int NumOutputs   = 4,
  parameter int DataWidth    = 8,
  parameter int AddrWidth    = 6,
  parameter int ClassWidth   = (NumOutputs > 1) ? $clog2(NumOutputs) : 1,
  parameter int RejectThresh = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  output logic                  ack_o,
  output logic                  ready_o,
  output logic [AddrWidth-1:0]  actv_ram_addr_o,
  input  logic [DataWidth-1:0]  actv_ram_rdata_i,
  output logic [ClassWidth-1:0] class_o,
  output logic [DataWidth-1:0]  max_o,
  output logic                  reject_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam logic [AddrWidth-1:0]  LastAddr = AddrWidth'(NumOutputs - 1);
  localparam logic [ClassWidth-1:0] LastIdx  = ClassWidth'(NumOutputs - 1);

  argmax_state_e         state_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [DataWidth-1:0]  run_max_q;
  logic [ClassWidth-1:0] run_idx_q;
  logic [ClassWidth-1:0] class_q;
  logic [DataWidth-1:0]  max_q;
  logic                  ack_q;
  logic                  ready_q;
  logic                  valid_q;

  logic                  cap_en;
  logic [ClassWidth-1:0] cap_idx;
  logic [DataWidth-1:0]  nxt_max;
  logic [ClassWidth-1:0] nxt_idx;

  // rdata always belongs to the address presented one cycle earlier
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = '0;
    if (state_q == READ && addr_q != '0) begin
      cap_en  = 1'b1;
      cap_idx = ClassWidth'(addr_q - AddrWidth'(ActvRamRdLatency));
    end else if (state_q == DRAIN) begin
      cap_en  = 1'b1;
      cap_idx = LastIdx;
    end
  end

  nn_max_cmp #(
    .DataWidth  (DataWidth),
    .ClassWidth (ClassWidth)
  ) u_max_cmp (
    .cur_max_i  (run_max_q),
    .cur_idx_i  (run_idx_q),
    .cand_i     (actv_ram_rdata_i),
    .cand_idx_i (cap_idx),
    .init_i     (cap_idx == '0),
    .max_o      (nxt_max),
    .idx_o      (nxt_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      class_q   <= '0;
      max_q     <= '0;
      ack_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (cap_en && state_q == READ) begin
        run_max_q <= nxt_max;
        run_idx_q <= nxt_idx;
      end
      case (state_q)
        IDLE: begin
          if (req_i) begin
            ack_q   <= 1'b1;
            ready_q <= 1'b0;
            addr_q  <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (addr_q == LastAddr) begin
            addr_q  <= '0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + AddrWidth'(1);
          end
        end
        DRAIN: begin
          class_q <= nxt_idx;
          max_q   <= nxt_max;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NN_ARGMAX_REJECT_EN
  localparam logic signed [DataWidth-1:0] Thresh = DataWidth'(RejectThresh);

  logic reject_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      reject_q <= 1'b0;
    end else if (state_q == DRAIN) begin
      reject_q <= $signed(nxt_max) < Thresh;
    end
  end

  assign reject_o = reject_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^DataWidth'(RejectThresh);
  assign reject_o      = 1'b0;
`endif

  assign ack_o           = ack_q;
  assign ready_o         = ready_q;
  assign valid_o         = valid_q;
  assign class_o         = class_q;
  assign max_o           = max_q;
  assign actv_ram_addr_o = addr_q;

endmodule
